// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Data wins by default; a pending fetch is forced through after MAX_DM_STREAK consecutive data grants.
module mem_port_arbiter #(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    output logic        if_stall_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        dm_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, DONE} state_t;

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic          w_grant_if;

    // Fetch wins when it is alone, or when data has used up its streak allowance.
    assign w_grant_if = if_req_i & (~dm_req_i | (r_streak == STREAK_MAX));
    assign if_stall_o = if_req_i & ~if_ack_o;
    assign dm_stall_o = dm_req_i & ~dm_ack_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
        end else begin
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_if) begin
                        r_state     <= IF_BUSY;
                        r_streak    <= '0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                    end else if (dm_req_i) begin
                        r_state     <= DM_BUSY;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        if (!if_req_i)
                            r_streak <= '0;
                        else if (r_streak != STREAK_MAX)
                            r_streak <= r_streak + 1'b1;
                    end
                end
                IF_BUSY: begin
                    if (mem_ack_i) begin
                        r_state   <= DONE;
                        mem_req_o <= 1'b0;
                        if_ack_o  <= 1'b1;
                        if_data_o <= mem_rdata_i;
                    end
                end
                DM_BUSY: begin
                    if (mem_ack_i) begin
                        r_state   <= DONE;
                        mem_req_o <= 1'b0;
                        dm_ack_o  <= 1'b1;
                        if (!mem_we_o)
                            dm_rdata_o <= mem_rdata_i;
                    end
                end
                // One dead cycle so the acknowledged requester can retire its request before IDLE samples again.
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_ack_o, if_stall_o;
    logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0, dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o, dm_stall_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;

    mem_port_arbiter #(.MAX_DM_STREAK(MAXS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem_arr [logic [31:0]];
    int  mem_lat = 1;
    int  mem_cnt = 0;
    bit  mem_auto = 1'b1;
    bit  mem_spur = 1'b0;
    bit  s_if_req, s_dm_req, s_dm_we, s_mem_ack;
    logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata;
    bit  prev_mem_req = 1'b0;
    bit  grant_now = 1'b0;
    logic [31:0] glog [$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0], 16'hC0DE} ^ 32'h1357_9BDF;
    endfunction

    // Advance one clock; afterwards outputs are sampled 1 time unit past the edge and the memory responds.
    task automatic step();
        s_if_req = if_req_i; s_if_addr = if_addr_i;
        s_dm_req = dm_req_i; s_dm_we = dm_we_i; s_dm_addr = dm_addr_i; s_dm_wdata = dm_wdata_i;
        s_mem_ack = mem_ack_i;
        @(posedge clk_i); #1;
        grant_now = mem_req_o && !prev_mem_req;
        prev_mem_req = mem_req_o;
        if (grant_now) glog.push_back(mem_addr_o);
        if (mem_auto) begin
            if (mem_req_o) begin
                if (mem_cnt == mem_lat) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) begin
                        mem_arr[mem_addr_o] = mem_wdata_o;
                        mem_rdata_i = $urandom;
                    end else begin
                        mem_rdata_i = mem_rd(mem_addr_o);
                    end
                end else begin
                    mem_ack_i = 1'b0;
                end
                mem_cnt++;
            end else begin
                mem_cnt = 0;
                mem_ack_i = mem_spur ? ($urandom_range(0, 3) == 0) : 1'b0;
                mem_rdata_i = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b0;
        mem_lat = 1; mem_spur = 1'b0; mem_auto = 1'b1;
        step(); step();
        rst_i = 1'b1;
        glog.delete();
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b0;
        step();
        n_checks++; if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o} !== 4'b0) begin n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000", {mem_req_o, mem_we_o, if_ack_o, dm_ack_o}); end
        n_checks++; if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin n_fail++;
            $display("FAIL reset_mem_fields: got %h want 0", {mem_addr_o, mem_wdata_o}); end
        n_checks++; if ({if_data_o, dm_rdata_o} !== 64'h0) begin n_fail++;
            $display("FAIL reset_rdata: got %h want 0", {if_data_o, dm_rdata_o}); end
        if_req_i = 1'b1; if_addr_i = 32'h10;
        step();
        n_checks++; if (mem_req_o !== 1'b0 || if_stall_o !== 1'b1) begin n_fail++;
            $display("FAIL reset_hold: mem_req=%b stall=%b want 0 1", mem_req_o, if_stall_o); end
        if_req_i = 1'b0;
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_fetch_only();
        int acks = 0, ack_cyc = -1;
        mem_arr[32'h40] = 32'h8C01_0004;
        mem_lat = 1;
        if_addr_i = 32'h40; if_req_i = 1'b1;
        #1;
        n_checks++; if (if_stall_o !== 1'b1) begin n_fail++;
            $display("FAIL fetch_stall_c0: got %b want 1", if_stall_o); end
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) begin
                n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h40) begin n_fail++;
                    $display("FAIL fetch_busy: req=%b we=%b addr=%h want 1 0 40", mem_req_o, mem_we_o, mem_addr_o); end
            end
            if (c <= 3) begin
                n_checks++; if (if_stall_o !== (c != 3)) begin n_fail++;
                    $display("FAIL fetch_stall_c%0d: got %b want %b", c, if_stall_o, c != 3); end
            end
            if (if_ack_o) begin
                acks++; ack_cyc = c; if_req_i = 1'b0;
                n_checks++; if (if_data_o !== 32'h8C01_0004) begin n_fail++;
                    $display("FAIL fetch_data: got %h want 8c010004", if_data_o); end
            end
        end
        n_checks++; if (acks != 1 || ack_cyc != 3) begin n_fail++;
            $display("FAIL fetch_ack: count %0d at cycle %0d want 1 at 3", acks, ack_cyc); end
    endtask

    task automatic test_simultaneous();
        bit if_done = 1'b0, dm_done = 1'b0;
        do_reset();
        mem_arr[32'h100] = 32'h55; mem_arr[32'h80] = 32'hA1B2_C3D4;
        if_addr_i = 32'h80; if_req_i = 1'b1;
        dm_addr_i = 32'h100; dm_we_i = 1'b0; dm_req_i = 1'b1;
        for (int c = 0; c < 30 && !(if_done && dm_done); c++) begin
            step();
            if (!if_done && !if_ack_o) begin
                n_checks++; if (if_data_o !== 32'h0) begin n_fail++;
                    $display("FAIL simul_if_hold: got %h want 0", if_data_o); end
            end
            if (dm_ack_o) begin
                dm_done = 1'b1; dm_req_i = 1'b0;
                n_checks++; if (dm_rdata_o !== 32'h55) begin n_fail++;
                    $display("FAIL simul_dm_data: got %h want 55", dm_rdata_o); end
            end
            if (if_ack_o) begin
                if_done = 1'b1; if_req_i = 1'b0;
                n_checks++; if (if_data_o !== 32'hA1B2_C3D4) begin n_fail++;
                    $display("FAIL simul_if_data: got %h want a1b2c3d4", if_data_o); end
            end
        end
        n_checks++; if (glog.size() != 2 || glog[0] !== 32'h100 || glog[1] !== 32'h80) begin n_fail++;
            $display("FAIL simul_order: %0d grants, first %h want 2 grants 100 then 80", glog.size(),
                     glog.size() > 0 ? glog[0] : 32'hX); end
        if_req_i = 1'b0; dm_req_i = 1'b0;
    endtask

    task automatic test_streak();
        logic [31:0] exp_order [7] = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h200, 32'h310, 32'h314};
        int n_st = 0;
        do_reset();
        if_addr_i = 32'h200; if_req_i = 1'b1;
        dm_addr_i = 32'h300; dm_we_i = 1'b1; dm_wdata_i = $urandom; dm_req_i = 1'b1;
        for (int c = 0; c < 100 && (if_req_i || dm_req_i); c++) begin
            step();
            if (grant_now && mem_addr_o == 32'h200) begin
                n_checks++; if (dut.r_streak !== '0) begin n_fail++;
                    $display("FAIL streak_clear: got %0d want 0", dut.r_streak); end
            end
            if (dm_ack_o) begin
                n_st++;
                if (n_st < 6) begin dm_addr_i = 32'h300 + 32'(4 * n_st); dm_wdata_i = $urandom; end
                else dm_req_i = 1'b0;
            end
            if (if_ack_o) if_req_i = 1'b0;
        end
        n_checks++; if (glog.size() != 7) begin n_fail++;
            $display("FAIL streak_count: got %0d grants want 7", glog.size()); end
        for (int i = 0; i < 7 && i < glog.size(); i++) begin
            n_checks++; if (glog[i] !== exp_order[i]) begin n_fail++;
                $display("FAIL streak_order[%0d]: got %h want %h", i, glog[i], exp_order[i]); end
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
    endtask

    task automatic test_store();
        int phase = 0, acks = 0;
        do_reset();
        mem_arr[32'h24] = 32'h11;
        mem_lat = 2;
        dm_addr_i = 32'h24; dm_we_i = 1'b0; dm_req_i = 1'b1;
        for (int c = 0; c < 40 && dm_req_i; c++) begin
            step();
            if (phase == 1 && mem_req_o) begin
                n_checks++; if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'hDEAD_BEEF || mem_addr_o !== 32'h20) begin n_fail++;
                    $display("FAIL store_fields: we=%b wdata=%h addr=%h want 1 deadbeef 20", mem_we_o, mem_wdata_o, mem_addr_o); end
                dm_wdata_i = 32'h0BAD_F00D; dm_addr_i = 32'h44;
            end
            if (dm_ack_o) begin
                acks++;
                n_checks++; if (dm_rdata_o !== 32'h11) begin n_fail++;
                    $display("FAIL store_rdata_ph%0d: got %h want 11", phase, dm_rdata_o); end
                if (phase == 0) begin
                    phase = 1; dm_addr_i = 32'h20; dm_we_i = 1'b1; dm_wdata_i = 32'hDEAD_BEEF;
                end else dm_req_i = 1'b0;
            end
        end
        n_checks++; if (acks != 2) begin n_fail++;
            $display("FAIL store_acks: got %0d want 2", acks); end
        dm_req_i = 1'b0;
    endtask

    task automatic test_long_latency();
        int busy = 0, acks = 0;
        do_reset();
        mem_lat = 5;
        if_addr_i = 32'h60; if_req_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mem_req_o) begin
                busy++;
                n_checks++; if (mem_addr_o !== 32'h60 || mem_we_o !== 1'b0) begin n_fail++;
                    $display("FAIL lat_stable: addr=%h we=%b want 60 0", mem_addr_o, mem_we_o); end
            end
            if (if_ack_o) begin acks++; if_req_i = 1'b0; end
        end
        n_checks++; if (busy != 6 || acks != 1) begin n_fail++;
            $display("FAIL lat_ack: busy %0d acks %0d want 6 1", busy, acks); end
        mem_auto = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++; if ({if_ack_o, dm_ack_o, mem_req_o} !== 3'b0) begin n_fail++;
                $display("FAIL spurious_ack: got %b want 000", {if_ack_o, dm_ack_o, mem_req_o}); end
        end
        n_checks++; if (if_data_o !== mem_rd(32'h60)) begin n_fail++;
            $display("FAIL spurious_data: got %h want %h", if_data_o, mem_rd(32'h60)); end
        mem_ack_i = 1'b0; mem_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        do_reset();
        mem_lat = 8;
        dm_addr_i = 32'h180; dm_we_i = 1'b0; dm_req_i = 1'b1;
        step(); step(); step();
        n_checks++; if (mem_req_o !== 1'b1) begin n_fail++;
            $display("FAIL rstmid_pre: mem_req got %b want 1", mem_req_o); end
        rst_i = 1'b0; dm_req_i = 1'b0; if_addr_i = 32'h1C0; if_req_i = 1'b1;
        #1;
        n_checks++; if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, mem_addr_o, dm_rdata_o} !== '0) begin n_fail++;
            $display("FAIL rstmid_immediate: req=%b addr=%h want 0 0", mem_req_o, mem_addr_o); end
        mem_lat = 1;
        step(); step();
        rst_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++; if (dm_ack_o !== 1'b0) begin n_fail++;
                $display("FAIL rstmid_no_dm_ack: got %b want 0", dm_ack_o); end
            if (grant_now) begin
                n_checks++; if (mem_addr_o !== 32'h1C0 || mem_we_o !== 1'b0) begin n_fail++;
                    $display("FAIL rstmid_grant: addr=%h we=%b want 1c0 0", mem_addr_o, mem_we_o); end
            end
            if (if_ack_o) begin
                acks++; if_req_i = 1'b0;
                n_checks++; if (if_data_o !== mem_rd(32'h1C0)) begin n_fail++;
                    $display("FAIL rstmid_data: got %h want %h", if_data_o, mem_rd(32'h1C0)); end
            end
        end
        n_checks++; if (acks != 1) begin n_fail++;
            $display("FAIL rstmid_acks: got %0d want 1", acks); end
    endtask

    task automatic test_random();
        int streak = 0, txns = 0;
        bit busy = 1'b0, owner_if = 1'b0, exp_ifack, exp_dmack;
        logic [31:0] exp_data = '0, last_if = '0, last_dm = '0;
        do_reset();
        mem_spur = 1'b1;
        for (int c = 0; c < 5000 && txns < 300; c++) begin
            step();
            exp_ifack = s_mem_ack && busy && owner_if;
            exp_dmack = s_mem_ack && busy && !owner_if;
            if (exp_ifack || exp_dmack) begin
                busy = 1'b0; txns++;
                if (exp_ifack) last_if = exp_data;
                else if (!mem_we_o) last_dm = exp_data;
            end
            if (grant_now) begin
                if (s_if_req && (!s_dm_req || streak == MAXS)) begin
                    owner_if = 1'b1; streak = 0; exp_data = mem_rd(s_if_addr);
                    n_checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b0, s_if_addr, 32'h0}) begin n_fail++;
                        $display("FAIL rand_if_grant: we=%b addr=%h wdata=%h want 0 %h 0", mem_we_o, mem_addr_o, mem_wdata_o, s_if_addr); end
                end else begin
                    owner_if = 1'b0; exp_data = mem_rd(s_dm_addr);
                    streak = s_if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                    n_checks++; if (!s_dm_req || {mem_we_o, mem_addr_o, mem_wdata_o} !== {s_dm_we, s_dm_addr, s_dm_wdata}) begin n_fail++;
                        $display("FAIL rand_dm_grant: req=%b we=%b addr=%h want %b %h", s_dm_req, mem_we_o, mem_addr_o, s_dm_we, s_dm_addr); end
                end
                busy = 1'b1;
            end
            n_checks++; if ({if_ack_o, dm_ack_o, mem_req_o} !== {exp_ifack, exp_dmack, busy}) begin n_fail++;
                $display("FAIL rand_ctrl c%0d: ack/req got %b want %b", c, {if_ack_o, dm_ack_o, mem_req_o}, {exp_ifack, exp_dmack, busy}); end
            n_checks++; if (if_data_o !== last_if || dm_rdata_o !== last_dm) begin n_fail++;
                $display("FAIL rand_data c%0d: if %h dm %h want %h %h", c, if_data_o, dm_rdata_o, last_if, last_dm); end
            n_checks++; if ({if_stall_o, dm_stall_o} !== {if_req_i && !exp_ifack, dm_req_i && !exp_dmack}) begin n_fail++;
                $display("FAIL rand_stall c%0d: got %b", c, {if_stall_o, dm_stall_o}); end
            if (!if_req_i || if_ack_o) begin
                if_req_i = ($urandom_range(0, 2) != 0); if_addr_i = 32'($urandom_range(0, 63)) << 2;
            end
            if (!dm_req_i || dm_ack_o) begin
                dm_req_i = ($urandom_range(0, 3) != 0); dm_we_i = $urandom_range(0, 1) == 1;
                dm_addr_i = 32'($urandom_range(0, 63)) << 2; dm_wdata_i = $urandom;
            end
            if (!mem_req_o) mem_lat = $urandom_range(0, 3);
        end
        n_checks++; if (txns < 300) begin n_fail++;
            $display("FAIL rand_progress: %0d transactions want 300", txns); end
        mem_spur = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_streak();
        test_store();
        test_long_latency();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch stage and MEM stage (load/store). It latches the winning request, holds the memory handshake until completion, returns read data with a one-cycle acknowledge, and drives per-stage stall signals that freeze PC, IFID and the downstream pipeline registers. The data port has priority, with a starvation guard for fetch.

## Interface
- MAX_DM_STREAK, 4, maximum consecutive data grants while a fetch is pending; the next grant goes to fetch. Valid range is at least 1.
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; level, held with if_addr_i stable until if_ack_o
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched instruction; valid when if_ack_o=1
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_stall_o  out  1  if_req_i & ~if_ack_o (combinational)
- dm_req_i  in  1  data request; level, held with dm_we_i/addr/wdata stable until dm_ack_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  32  data address
- dm_wdata_i  in  32  store data
- dm_rdata_o  out  32  load data; valid when dm_ack_o=1
- dm_ack_o  out  1  one-cycle data completion pulse
- dm_stall_o  out  1  dm_req_i & ~dm_ack_o (combinational)
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data; valid with mem_ack_i
- mem_ack_i  in  1  memory completion, sampled only in IF_BUSY/DM_BUSY

## Operation
- States: IDLE, IF_BUSY, DM_BUSY, DONE.
- IDLE:
  - Only dm_req_i: go to DM_BUSY.
  - Only if_req_i: go to IF_BUSY.
  - Both: go to IF_BUSY if streak == MAX_DM_STREAK, else DM_BUSY.
  - Neither: stay in IDLE.
  - At the grant edge, latch we/addr/wdata from the winner into mem_* registers. A fetch latches mem_we_o=0 and mem_wdata_o=0.
- IF_BUSY/DM_BUSY: mem_req_o=1 with latched fields stable. On mem_ack_i=1:
  - Capture mem_rdata_i into if_data_o (IF) or dm_rdata_o (DM load).
  - Go to DONE and record the owner.
- DONE (exactly one cycle):
  - Assert if_ack_o or dm_ack_o for the owner; mem_req_o=0.
  - No grant is made in DONE. The requester deasserts or changes its request before IDLE samples it.
  - Next state is IDLE.
- Streak counter, width clog2(MAX_DM_STREAK+1):
  - Cleared on every IF grant.
  - On a DM grant: if_req_i=1 increments it (saturating at MAX_DM_STREAK); if_req_i=0 clears it.
- A store leaves dm_rdata_o unchanged. if_data_o and dm_rdata_o change only on their own read completion.
- mem_ack_i in IDLE or DONE is ignored.
- Changing request fields mid-transaction has no effect; the latched values are used.

## Timing
- Reset values (rst_i=0, asynchronous):
  - State IDLE, streak 0.
  - mem_req_o, mem_we_o = 0; mem_addr_o, mem_wdata_o = 0.
  - if_ack_o, dm_ack_o = 0; if_data_o, dm_rdata_o = 0.
- Reset mid-transaction drops mem_req_o immediately and abandons the access; no ack is issued.
- Latency: request seen in IDLE at cycle 0 gives mem_req_o=1 in cycle 1. If mem_ack_i arrives in cycle k≥1, ack_o is high in cycle k+1 and IDLE is reached in cycle k+2.
- Minimum turnaround is 3 cycles per access. Back-to-back grants are separated by one DONE cycle plus one IDLE cycle.
- Stall outputs are high from the first request cycle through the cycle before ack_o; they are low in the ack cycle.
- mem_* outputs are registered. ack_o and rdata outputs are registered. Stall outputs are combinational from the request and ack inputs.

## Test plan
- Fetch only, addr 0x40, memory acks one cycle after mem_req_o with 0x8C010004. Required: if_ack_o pulses exactly once, if_data_o = 0x8C010004, if_stall_o is high until the ack cycle, mem_we_o = 0.
- Simultaneous if_req_i and dm_req_i (load 0x100, mem returns 0x55). Required: DM is granted first and dm_rdata_o = 0x55. IF is granted next; if_data_o holds 0 until its own ack.
- if_req_i held while dm_req_i issues 6 back-to-back stores, MAX_DM_STREAK=4. Required grant order: DM ×4, IF, DM ×2. Streak is 0 after the IF grant.
- Store 0xDEADBEEF to 0x20 after a prior load returned 0x11. Required: mem_we_o=1 and mem_wdata_o=0xDEADBEEF during DM_BUSY. dm_ack_o pulses; dm_rdata_o remains 0x11.
- mem_ack_i held low for 5 cycles, then pulsed. Required: mem_req_o/addr stable all 5 cycles and a single ack follows. A spurious mem_ack_i in IDLE produces no ack.
- rst_i driven low during DM_BUSY. Required: mem_req_o=0 in the same cycle, no dm_ack_o, all outputs at reset values. After release, a pending if_req_i is granted from IDLE normally.
